// File: rtl/gpio_bus_writer.sv
// Serialises a captured address/payload onto a GPIO-style parallel bus, one byte
// per w_clk strobe, most-significant byte first, with programmable setup/strobe/hold.
module gpio_bus_writer #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 2,
  parameter int MAX_BYTES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_nbytes,
  output logic [31:0] gpio_out,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_e;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [2:0] MAX_N     = 3'(MAX_BYTES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] gpio_q, gpio_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  byte_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          data_d = req_data;
          if (req_nbytes != 3'd0 && req_nbytes <= MAX_N) begin
            state_d = SETUP;
            // n = 4 wraps to 0 in two bits, so n-1 still lands on index 3
            idx_d   = req_nbytes[1:0] - 2'd1;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          if (idx_q == 2'd0) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            idx_d   = idx_q - 2'd1;
            cnt_d   = SETUP_LD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    byte_d = data_d[{idx_d, 3'b000} +: 8];
    gpio_d = '0;
    if (state_d inside {SETUP, STROBE, HOLD}) begin
      gpio_d[15:0]  = addr_d;
      gpio_d[23:16] = byte_d;
      gpio_d[24]    = (state_d == STROBE);
    end
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gpio_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gpio_q  <= gpio_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign gpio_out  = gpio_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
